// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester bitwise logic unit scheduler:
// opcode numbering and scheduler state encoding.
package alu_pkg;

  // Opcode numbering of the combinational logic unit
  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NAND = 3;
  localparam int OP_NOR  = 4;
  localparam int OP_XNOR = 5;
  localparam int OP_NOTA = 6;
  localparam int OP_PASS = 7;

  // Scheduler sequencing: accept one op, evaluate it, hold the result
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_logic_unit.sv
// Purely combinational WIDTH-bit bitwise gate datapath selected by opcode.
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  // Select one bitwise function; unknown opcodes yield zero
  always_comb begin
    r = '0;
    case (op)
      OPW'(OP_AND):  r = a & b;
      OPW'(OP_OR):   r = a | b;
      OPW'(OP_XOR):  r = a ^ b;
      OPW'(OP_NAND): r = ~(a & b);
      OPW'(OP_NOR):  r = ~(a | b);
      OPW'(OP_XNOR): r = ~(a ^ b);
      OPW'(OP_NOTA): r = ~a;
      OPW'(OP_PASS): r = a;
      default:       r = '0;
    endcase
  end

endmodule

// File: rtl/alu_logic_arbiter.sv
// Round-robin scheduler in front of the shared logic unit. Accepts one op
// from either requester while idle, evaluates it, then holds the tagged
// result until the consumer takes it. One op in flight at a time.
module alu_logic_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_zero
);

  state_t           state;
  logic [OPW-1:0]   op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             id_reg;
  logic             last_id;
  logic             grant_any;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] alu_r;

  // Pick the winner: a lone requester always wins, a tie goes to the one not served last
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id;
    end else begin
      grant_id = req1_valid;
    end
  end

  // Ready only while idle and out of reset, so a reset cycle never hands out a grant
  assign accept     = rst_n && (state == S_IDLE) && grant_any;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  alu_logic_unit #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_unit (
    .op(op_reg),
    .a (a_reg),
    .b (b_reg),
    .r (alu_r)
  );

  // Sequencer: capture on grant, register result, hold until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      id_reg    <= 1'b0;
      last_id   <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            op_reg  <= grant_id ? req1_op : req0_op;
            a_reg   <= grant_id ? req1_a  : req0_a;
            b_reg   <= grant_id ? req1_b  : req0_b;
            id_reg  <= grant_id;
            last_id <= grant_id;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data  <= alu_r;
          res_zero  <= (alu_r == '0);
          res_id    <= id_reg;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed bench for alu_logic_arbiter: inputs change on the falling edge,
// outputs are sampled 1ns later, well away from the rising edge.
module tb_alu_logic_arbiter;

  localparam int WIDTH = 16;
  localparam int OPW   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id, res_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_logic_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_zero  (res_zero)
  );

  // advance one full cycle, ending on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // wait (bounded) for the given requester's ready; ends 1ns after a falling edge
  task automatic wait_ready(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((which == 0 && req0_ready) || (which == 1 && req1_ready)) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // wait (bounded) for res_valid
  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (res_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    vectors++;
    if (res_valid !== 1'b0 || res_data !== 16'h0000 || res_id !== 1'b0 || res_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%b z=%b want 0/0000/0/0",
               res_valid, res_data, res_id, res_zero);
    end
    $display("test_reset: ready=%b%b res_valid=%b", req0_ready, req1_ready, res_valid);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_nand();
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 16'h00F8; req0_b = 16'h0147;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    vectors++;
    if (res_valid !== 1'b0 || req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_exec: got v=%b r0=%b want 0 0", res_valid, req0_ready);
    end
    tick();
    #1;
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 16'hFFBF || res_id !== 1'b0 || res_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL single_result: got v=%b d=%h id=%b z=%b want 1/ffbf/0/0",
               res_valid, res_data, res_id, res_zero);
    end
    $display("test_single_nand: data=%h id=%b", res_data, res_id);
    tick();
    #1;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: got v=%b want 0", res_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_both_valid();
    bit ok;
    // fresh reset so the pointer is back at its initial value
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h00F8; req0_b = 16'h0147;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 16'h00F8; req1_b = 16'h0147;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL both_first_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    wait_result(ok);
    vectors++;
    if (!ok || res_data !== 16'h0040 || res_id !== 1'b0) begin
      miscompares++;
      $display("FAIL both_first_result: got ok=%b d=%h id=%b want 1/0040/0", ok, res_data, res_id);
    end
    tick();
    wait_ready(1, ok);
    vectors++;
    if (!ok || req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL both_second_grant: got ok=%b r0=%b want 1 0", ok, req0_ready);
    end
    tick();
    req1_valid = 1'b0;
    wait_result(ok);
    vectors++;
    if (!ok || res_data !== 16'h0040 || res_id !== 1'b1) begin
      miscompares++;
      $display("FAIL both_second_result: got ok=%b d=%h id=%b want 1/0040/1", ok, res_data, res_id);
    end
    $display("test_both_valid: second id=%b data=%h", res_id, res_data);
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int got;
    int last;
    last = 1;  // requester 1 was served last in the previous test
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 16'h1200; req0_b = 16'h0034;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 16'hFFFF; req1_b = 16'h0F0F;
    for (int n = 0; n < 4; n++) begin
      ok = 1'b0;
      got = -1;
      for (int i = 0; i < 20 && !ok; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          ok = 1'b1;
          got = req1_ready ? 1 : 0;
        end else begin
          tick();
        end
      end
      vectors++;
      if (!ok || got != (1 - last) || (req0_ready && req1_ready)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got ok=%b id=%0d both=%b want id %0d", n, ok, got,
                 req0_ready && req1_ready, 1 - last);
      end
      last = got;
      tick();
      wait_result(ok);
      vectors++;
      if (!ok || res_id !== (n % 2 == 1) ||
          res_data !== ((n % 2 == 0) ? 16'h1234 : 16'hF0F0)) begin
        miscompares++;
        $display("FAIL rr_result%0d: got ok=%b id=%b d=%h", n, ok, res_id, res_data);
      end
      $display("test_back_to_back: op %0d granted id=%0d data=%h", n, got, res_data);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 16'hA5A5; req1_b = 16'hA5A5;
    res_ready = 1'b0;
    wait_ready(1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_grant: req1_ready never rose");
    end
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd7; req0_a = 16'h5555; req0_b = 16'h0000;
    wait_result(ok);
    bad = !ok;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_zero !== 1'b1 ||
          res_id !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL bp_hold: got v=%b d=%h z=%b id=%b r=%b%b want 1/0000/1/1/00",
               res_valid, res_data, res_zero, res_id, req0_ready, req1_ready);
    end
    res_ready = 1'b1;
    tick();
    #1;
    vectors++;
    if (res_valid !== 1'b0 || req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b r0=%b want 0 1", res_valid, req0_ready);
    end
    $display("test_backpressure: held zero result, then req0 ready=%b", req0_ready);
    req0_valid = 1'b0;  // withdraw before the edge
    tick();
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    // requester 0 wins alone, moving the pointer to 0, then reset hits in EXEC
    req0_valid = 1'b1; req0_op = 3'd7; req0_a = 16'h1111; req0_b = 16'h0000;
    wait_ready(0, ok);
    tick();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 16'h00F0; req0_b = 16'h000F;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 16'h0F00; req1_b = 16'hF000;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_gate_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    tick();
    #1;
    vectors++;
    if (res_valid !== 1'b0 || res_data !== 16'h0000 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_op: got v=%b d=%h r=%b%b want 0/0000/00",
               res_valid, res_data, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pointer: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_result(ok);
    vectors++;
    if (!ok || res_data !== 16'h00FF || res_id !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_new_result: got ok=%b d=%h id=%b want 1/00ff/0", ok, res_data, res_id);
    end
    $display("test_reset_mid_op: post-reset data=%h id=%b", res_data, res_id);
    tick();
  endtask

  task automatic test_opcodes();
    bit ok;
    logic [WIDTH-1:0] exp_tbl [8];
    exp_tbl[0] = 16'h0040; exp_tbl[1] = 16'h01FF; exp_tbl[2] = 16'h01BF; exp_tbl[3] = 16'hFFBF;
    exp_tbl[4] = 16'hFE00; exp_tbl[5] = 16'hFE40; exp_tbl[6] = 16'hFF07; exp_tbl[7] = 16'h00F8;
    for (int op = 0; op < 8; op++) begin
      req0_valid = 1'b1; req0_op = OPW'(op); req0_a = 16'h00F8; req0_b = 16'h0147;
      wait_ready(0, ok);
      tick();
      req0_valid = 1'b0;
      if (ok) wait_result(ok);
      vectors++;
      if (!ok || res_data !== exp_tbl[op] || res_zero !== 1'b0 || res_id !== 1'b0) begin
        miscompares++;
        $display("FAIL opcode%0d: got ok=%b d=%h z=%b id=%b want %h", op, ok, res_data,
                 res_zero, res_id, exp_tbl[op]);
      end
      $display("test_opcodes: op=%0d data=%h", op, res_data);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_nand();
    test_both_valid();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_opcodes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
